pc_branch_unit: RTL and testbench

//  Datapath sequencing stage directly downstream of the multicycle control FSM.

---
 rtl/pc_branch_unit.sv | 96 +++++++++
 tb/tb_pc_branch_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_branch_unit.sv
// PC / instruction register / ALUOut sequencing stage driven by the multicycle control FSM.
// Resolves branch/jump targets, counts retired and taken instructions, flags illegal controls.
module pc_branch_unit #(
  parameter int unsigned       WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = '0,
  parameter int unsigned       CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PCWrite,
  input  logic             BEQ,
  input  logic             BNE,
  input  logic [1:0]       PCSrc,
  input  logic             IRWrite,
  input  logic [3:0]       current_state,
  input  logic [WIDTH-1:0] ALUResult,
  input  logic             Zero,
  input  logic [WIDTH-1:0] MemRdData,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] Instr,
  output logic [WIDTH-1:0] ALUOut,
  output logic             PCEn,
  output logic             branch_taken,
  output logic [CNT_W-1:0] retired_count,
  output logic [CNT_W-1:0] taken_count,
  output logic [2:0]       err
);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_instr;
  logic [WIDTH-1:0] r_alu_out;
  logic             r_branch_taken;
  logic [CNT_W-1:0] r_retired;
  logic [CNT_W-1:0] r_taken;
  logic [2:0]       r_err;

  logic             w_take;
  logic             w_pcen;
  logic             w_retire;
  logic [WIDTH-1:0] w_pc_next;

  // A conflicting BEQ&BNE request never branches; it is only reported.
  assign w_take = (BEQ & ~BNE & Zero) | (BNE & ~BEQ & ~Zero);
  assign w_pcen = PCWrite | w_take;

  always_comb begin
    w_pc_next = r_pc;
    unique case (PCSrc)
      2'b00:   w_pc_next = ALUResult;
      2'b01:   w_pc_next = r_alu_out;
      2'b10:   w_pc_next = {r_pc[WIDTH-1:28], r_instr[25:0], 2'b00};
      default: w_pc_next = r_pc;
    endcase
  end

  // Retiring states: Mem_Writeback, Mem_Write, ALU_Writeback, Branch_BEQ, Branch_BNE, Jump.
  always_comb begin
    w_retire = 1'b0;
    case (current_state)
      4'd4, 4'd5, 4'd7, 4'd8, 4'd9, 4'd10: w_retire = 1'b1;
      default:                             w_retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc           <= RESET_PC;
      r_instr        <= '0;
      r_alu_out      <= '0;
      r_branch_taken <= 1'b0;
      r_retired      <= '0;
      r_taken        <= '0;
      r_err          <= '0;
    end else begin
      r_alu_out      <= ALUResult;
      r_branch_taken <= w_take;
      if (IRWrite) r_instr <= MemRdData;
      if (w_pcen) r_pc <= {w_pc_next[WIDTH-1:2], 2'b00};
      if (w_take && (r_taken != '1)) r_taken <= r_taken + 1'b1;
      if (w_retire && (r_retired != '1)) r_retired <= r_retired + 1'b1;
      if (w_pcen && (PCSrc == 2'b11)) r_err[0] <= 1'b1;
      if (w_pcen && (w_pc_next[1:0] != 2'b00)) r_err[1] <= 1'b1;
      if (BEQ && BNE) r_err[2] <= 1'b1;
    end
  end

  assign PC            = r_pc;
  assign Instr         = r_instr;
  assign ALUOut        = r_alu_out;
  assign PCEn          = w_pcen;
  assign branch_taken  = r_branch_taken;
  assign retired_count = r_retired;
  assign taken_count   = r_taken;
  assign err           = r_err;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: one default-width instance and one with 4-bit counters
// share the same stimulus so counter saturation and non-saturation are seen side by side.
module tb_pc_branch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCWrite, BEQ, BNE, IRWrite, Zero;
  logic [1:0]  PCSrc;
  logic [3:0]  current_state;
  logic [31:0] ALUResult, MemRdData;

  logic [31:0] pc_a, instr_a, aluout_a;
  logic        pcen_a, bt_a;
  logic [15:0] ret_a, tak_a;
  logic [2:0]  err_a;

  logic [31:0] pc_b, instr_b, aluout_b;
  logic        pcen_b, bt_b;
  logic [3:0]  ret_b, tak_b;
  logic [2:0]  err_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_branch_unit dut_a (
    .clk(clk), .rst(rst), .PCWrite(PCWrite), .BEQ(BEQ), .BNE(BNE), .PCSrc(PCSrc),
    .IRWrite(IRWrite), .current_state(current_state), .ALUResult(ALUResult), .Zero(Zero),
    .MemRdData(MemRdData), .PC(pc_a), .Instr(instr_a), .ALUOut(aluout_a), .PCEn(pcen_a),
    .branch_taken(bt_a), .retired_count(ret_a), .taken_count(tak_a), .err(err_a)
  );

  pc_branch_unit #(.CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .PCWrite(PCWrite), .BEQ(BEQ), .BNE(BNE), .PCSrc(PCSrc),
    .IRWrite(IRWrite), .current_state(current_state), .ALUResult(ALUResult), .Zero(Zero),
    .MemRdData(MemRdData), .PC(pc_b), .Instr(instr_b), .ALUOut(aluout_b), .PCEn(pcen_b),
    .branch_taken(bt_b), .retired_count(ret_b), .taken_count(tak_b), .err(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ctrl();
    PCWrite = 0; BEQ = 0; BNE = 0; PCSrc = 2'b00; IRWrite = 0; Zero = 0; current_state = 4'd0;
  endtask

  // Registered state of both instances; counters given separately for each width.
  task automatic chk_regs(input string tag, input logic [31:0] pc, input logic [31:0] bt,
                          input logic [31:0] tk_a, input logic [31:0] rt_a,
                          input logic [31:0] tk_b, input logic [31:0] rt_b,
                          input logic [31:0] e);
    chk({tag, ".pc"}, pc_a, pc);
    chk({tag, ".pc_b"}, pc_b, pc);
    chk({tag, ".bt"}, {31'd0, bt_a}, bt);
    chk({tag, ".taken"}, {16'd0, tak_a}, tk_a);
    chk({tag, ".retired"}, {16'd0, ret_a}, rt_a);
    chk({tag, ".taken_b"}, {28'd0, tak_b}, tk_b);
    chk({tag, ".retired_b"}, {28'd0, ret_b}, rt_b);
    chk({tag, ".err"}, {29'd0, err_a}, e);
  endtask

  initial begin
    // Reset held with every other input active: reset must win.
    rst = 1; PCWrite = 1; BEQ = 0; BNE = 1; PCSrc = 2'b00; IRWrite = 1; Zero = 0;
    current_state = 4'd7; ALUResult = 32'h0000_1234; MemRdData = 32'hFFFF_FFFF;
    step(); step();
    chk_regs("reset", 32'h0, 0, 0, 0, 0, 0, 0);
    chk("reset.instr", instr_a, 32'h0);
    chk("reset.aluout", aluout_a, 32'h0);

    // Fetch
    rst = 0; idle_ctrl();
    PCWrite = 1; IRWrite = 1; ALUResult = 32'h4; MemRdData = 32'h8C01_0008;
    #1 chk("fetch.pcen", {31'd0, pcen_a}, 1);
    step();
    chk("fetch.pc", pc_a, 32'h4);
    chk("fetch.instr", instr_a, 32'h8C01_0008);
    chk("fetch.aluout", aluout_a, 32'h4);

    // BEQ taken to ALUOut=0x40
    idle_ctrl(); current_state = 4'd1; ALUResult = 32'h40;
    step();
    chk("beq_setup.aluout", aluout_a, 32'h40);
    idle_ctrl(); BEQ = 1; Zero = 1; PCSrc = 2'b01; current_state = 4'd8; ALUResult = 32'h0;
    #1 chk("beq_t.pcen", {31'd0, pcen_a}, 1);
    step();
    chk_regs("beq_t", 32'h40, 1, 1, 1, 1, 1, 0);

    // BEQ not taken
    idle_ctrl(); current_state = 4'd1; ALUResult = 32'h80;
    step();
    chk("beq_nt_setup.bt", {31'd0, bt_a}, 0);
    idle_ctrl(); BEQ = 1; Zero = 0; PCSrc = 2'b01; current_state = 4'd8; ALUResult = 32'h5;
    #1 chk("beq_nt.pcen", {31'd0, pcen_a}, 0);
    step();
    chk_regs("beq_nt", 32'h40, 0, 1, 2, 1, 2, 0);

    // BNE taken to 0x100, then BNE not taken
    idle_ctrl(); current_state = 4'd1; ALUResult = 32'h100;
    step();
    idle_ctrl(); BNE = 1; Zero = 0; PCSrc = 2'b01; current_state = 4'd9; ALUResult = 32'h3;
    #1 chk("bne_t.pcen", {31'd0, pcen_a}, 1);
    step();
    chk_regs("bne_t", 32'h100, 1, 2, 3, 2, 3, 0);
    idle_ctrl(); BNE = 1; Zero = 1; PCSrc = 2'b01; current_state = 4'd9;
    #1 chk("bne_nt.pcen", {31'd0, pcen_a}, 0);
    step();
    chk_regs("bne_nt", 32'h100, 0, 2, 4, 2, 4, 0);

    // Jump: upper PC nibble kept, target from Instr[25:0]<<2
    idle_ctrl(); PCWrite = 1; IRWrite = 1; ALUResult = 32'h3000_0010; MemRdData = 32'h0800_0040;
    step();
    chk("jmp_setup.pc", pc_a, 32'h3000_0010);
    chk("jmp_setup.instr", instr_a, 32'h0800_0040);
    idle_ctrl(); PCWrite = 1; PCSrc = 2'b10; current_state = 4'd10; ALUResult = 32'h0;
    step();
    chk_regs("jump", 32'h3000_0100, 0, 2, 5, 2, 5, 0);

    // Illegal PCSrc=11: PC held, err[0]
    idle_ctrl(); PCWrite = 1; PCSrc = 2'b11;
    #1 chk("src11.pcen", {31'd0, pcen_a}, 1);
    step();
    chk_regs("src11", 32'h3000_0100, 0, 2, 5, 2, 5, 32'b001);

    // Misaligned target: LSBs forced to 00, err[1]
    idle_ctrl(); PCWrite = 1; PCSrc = 2'b00; ALUResult = 32'h6;
    step();
    chk_regs("misalign", 32'h4, 0, 2, 5, 2, 5, 32'b011);

    // BEQ&BNE together: no branch, err[2]
    idle_ctrl(); BEQ = 1; BNE = 1; Zero = 1; PCSrc = 2'b01; current_state = 4'd8;
    #1 chk("both.pcen", {31'd0, pcen_a}, 0);
    step();
    chk_regs("both", 32'h4, 0, 2, 6, 2, 6, 32'b111);
    chk("both.err_b", {29'd0, err_b}, 32'b111);

    // Reset clears sticky errors
    idle_ctrl(); rst = 1;
    step();
    chk_regs("err_clr", 32'h0, 0, 0, 0, 0, 0, 0);
    rst = 0;

    // Non-retiring codes (incl. undefined 11-15) do not count
    for (int s = 0; s < 16; s++) begin
      if (!(s inside {4, 5, 7, 8, 9, 10})) begin
        idle_ctrl(); current_state = s[3:0];
        step();
      end
    end
    chk("noretire.a", {16'd0, ret_a}, 0);

    // 20 retire cycles: 4-bit counter saturates at 15, 16-bit reaches 20
    for (int i = 0; i < 20; i++) begin
      idle_ctrl();
      case (i % 6)
        0: current_state = 4'd4;
        1: current_state = 4'd5;
        2: current_state = 4'd7;
        3: current_state = 4'd8;
        4: current_state = 4'd9;
        default: current_state = 4'd10;
      endcase
      step();
    end
    chk_regs("ret_sat", 32'h0, 0, 0, 20, 0, 15, 0);

    // 17 taken BNE branches: taken_count saturates on the narrow instance
    for (int i = 0; i < 17; i++) begin
      idle_ctrl(); BNE = 1; Zero = 0; current_state = 4'd9; ALUResult = 32'h200;
      step();
    end
    chk_regs("tak_sat", 32'h200, 1, 17, 37, 15, 15, 0);

    // Load Instr, then reset mid-Execute with updates requested
    idle_ctrl(); IRWrite = 1; MemRdData = 32'hCAFE_F00D; current_state = 4'd6;
    step();
    chk("pre_rst.instr", instr_a, 32'hCAFE_F00D);
    idle_ctrl(); rst = 1; PCWrite = 1; IRWrite = 1; current_state = 4'd6;
    ALUResult = 32'h500; MemRdData = 32'h1234_5678;
    step();
    chk_regs("mid_rst", 32'h0, 0, 0, 0, 0, 0, 0);
    chk("mid_rst.instr", instr_a, 32'h0);
    chk("mid_rst.aluout", aluout_a, 32'h0);
    chk("mid_rst.instr_b", instr_b, 32'h0);
    chk("mid_rst.aluout_b", aluout_b, 32'h0);
    chk("mid_rst.bt_b", {31'd0, bt_b}, 0);
    chk("mid_rst.pcen_b", {31'd0, pcen_b}, 1);
    rst = 0; idle_ctrl();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
